shift_add_mul_45bit: RTL and testbench



---
 rtl/mul_pkg.sv | 16 +
 rtl/shift_add_mul_45bit_fa.sv | 24 ++
 rtl/shift_add_mul_45bit.sv | 93 +++++++++
 tb/tb_shift_add_mul_45bit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizes for the shift-and-add multiplier.
// Holds operand width, counter width, FSM states and product type.
package mul_pkg;

    localparam int MUL_WIDTH = 45;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    typedef logic [2*MUL_WIDTH-1:0] mul_prod_t;

endpackage

// File: rtl/shift_add_mul_45bit_fa.sv
// FA_45bit: ripple-carry adder built from per-bit full adders.
// Ports: A, B (width), cin -> S (width), cout.
module FA_45bit #(
    parameter int width = 45
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             cin,
    output logic [width-1:0] S,
    output logic             cout
);

    logic [width:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < width; i++) begin : g_bit
        assign S[i]     = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign cout = w_c[width];

endmodule

// File: rtl/shift_add_mul_45bit.sv
// Sequential unsigned shift-and-add multiplier over one FA_45bit.
// Ports: clk, rst_n, start, a, b -> busy, done, p (2*width).
module shift_add_mul_45bit
    import mul_pkg::*;
#(
    parameter int width = MUL_WIDTH,
    parameter int cnt_w = MUL_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*width-1:0] p
);

    mul_state_t r_state;
    mul_state_t w_next;

    logic [width-1:0]   r_mcand;
    logic [width-1:0]   r_acc;
    logic [width-1:0]   r_mq;
    logic [cnt_w-1:0]   r_cnt;
    logic [2*width-1:0] r_p;

    logic [width-1:0]   w_addend;
    logic [width-1:0]   w_sum;
    logic               w_cout;
    logic               w_last;
    logic [2*width-1:0] w_shift;

    assign w_addend = r_mq[0] ? r_mcand : '0;

    FA_45bit #(
        .width(width)
    ) u_fa (
        .A   (r_acc),
        .B   (w_addend),
        .cin (1'b0),
        .S   (w_sum),
        .cout(w_cout)
    );

    // Carry lands in the acc MSB; mq LSB (already consumed) drops out.
    assign w_shift = {w_cout, w_sum, r_mq[width-1:1]};
    assign w_last  = (r_cnt == cnt_w'(width - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else if (r_state == IDLE && start) begin
            r_mcand <= a;
            r_acc   <= '0;
            r_mq    <= b;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            {r_acc, r_mq} <= w_shift;
            r_cnt         <= r_cnt + cnt_w'(1);
            if (w_last) begin
                r_p <= w_shift;
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign p    = r_p;

endmodule

// File: tb/tb_shift_add_mul_45bit.sv
// Randomized self-checking bench for shift_add_mul_45bit.
// Reference product is plain 90-bit multiplication.
module tb_shift_add_mul_45bit;

    localparam int W = 45;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  p;

    int              n_tests;
    int              n_fail;
    logic [2*W-1:0]  last_p;

    shift_add_mul_45bit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .p    (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [2*W-1:0] obs,
                       input logic [2*W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation; checks product, latency, busy span, p hold.
    task automatic do_mul(input logic [W-1:0] ta,
                          input logic [W-1:0] tb,
                          input string tag,
                          input bit timing);
        logic [2*W-1:0] expv;
        int n_busy;
        int n_done;
        int lat;
        bit idle;
        expv   = {{W{1'b0}}, ta} * {{W{1'b0}}, tb};
        n_busy = 0;
        n_done = 0;
        lat    = -1;
        idle   = 1'b0;
        @(negedge clk);
        a     = ta;
        b     = tb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 20) chk({tag, "_hold"}, p, last_p);
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (lat < 0) lat = i;
                chk({tag, "_p"}, p, expv);
            end
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        chk({tag, "_idle"}, 90'(idle), 90'd1);
        if (timing) begin
            chk({tag, "_lat"}, 90'(lat), 90'd45);
            chk({tag, "_ndone"}, 90'(n_done), 90'd1);
            chk({tag, "_nbusy"}, 90'(n_busy), 90'd46);
        end
        last_p = expv;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] ones;
        int dn[$];
        bit seen;

        n_tests = 0;
        n_fail  = 0;
        last_p  = '0;
        ones    = '1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 90'(busy), 90'd0);
        chk("rst_done", 90'(done), 90'd0);
        chk("rst_p", p, 90'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_mul(45'd3, 45'd5, "small", 1'b1);
        do_mul(ones, ones, "max", 1'b1);
        do_mul(45'd0, ones, "zero_a", 1'b1);
        do_mul(ones, 45'd0, "zero_b", 1'b1);
        do_mul(45'd1, 45'h1_2345_6789, "one", 1'b1);

        // start held high: back-to-back results every width+2 cycles
        @(negedge clk);
        a     = 45'd7;
        b     = 45'd9;
        start = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done) begin
                dn.push_back(i);
                chk("cont_p", p, 90'd63);
            end
        end
        start = 1'b0;
        chk("cont_n", 90'(dn.size()), 90'd3);
        for (int k = 1; k < dn.size(); k++) begin
            chk("cont_gap", 90'(dn[k] - dn[k-1]), 90'd47);
        end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("cont_idle", 90'(seen), 90'd1);
        last_p = 90'd63;

        // asynchronous reset mid-run
        @(negedge clk);
        a     = 45'h1F_0F0F_0F0F;
        b     = 45'h0A_AAAA_AAAA;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", 90'(busy), 90'd0);
        chk("arst_done", 90'(done), 90'd0);
        chk("arst_p", p, 90'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("arst_nodone", 90'(seen), 90'd0);
        rst_n  = 1'b1;
        last_p = '0;
        do_mul(45'd10, 45'd10, "post_rst", 1'b1);

        for (int n = 0; n < 1000; n++) begin
            ra = W'({$urandom, $urandom});
            rb = W'({$urandom, $urandom});
            if (n % 50 == 1) ra = ones;
            if (n % 50 == 2) rb = ones;
            if (n % 50 == 3) rb = '0;
            do_mul(ra, rb, "rand", (n % 100 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
